// File: rtl/icache.sv
// Direct-mapped instruction cache: 16 one-word entries, blocking miss handling
// with a two-state IDLE/FETCH controller in front of the memory controller.
module icache (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned NUM_ENTRIES = 16;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned TAG_W       = 26;
  localparam int unsigned WORD_W      = 32;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]             r_state;
  logic [0:0]             w_next_state;
  logic [WORD_W-1:0]      r_miss_addr;
  logic [NUM_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag  [NUM_ENTRIES];
  logic [WORD_W-1:0]      r_data [NUM_ENTRIES];

  logic [IDX_W-1:0]       w_req_idx;
  logic [TAG_W-1:0]       w_req_tag;
  logic [IDX_W-1:0]       w_fill_idx;
  logic [TAG_W-1:0]       w_fill_tag;
  logic                   w_lookup;
  logic                   w_miss;
  logic                   w_fill;
  logic                   w_unused_offset;

  // Address decode for the incoming request and the latched miss
  assign w_req_idx       = imemaddr[5:2];
  assign w_req_tag       = imemaddr[31:6];
  assign w_fill_idx      = r_miss_addr[5:2];
  assign w_fill_tag      = r_miss_addr[31:6];
  assign w_unused_offset = ^imemaddr[1:0];

  // Tag compare against the indexed entry; only meaningful while idle
  assign w_lookup = imemREN && r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);

  // State register; reset aborts any fetch in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath-facing outputs
  always_comb begin
    w_next_state = r_state;
    w_miss       = 1'b0;
    w_fill       = 1'b0;
    ihit         = 1'b0;
    imemload     = 32'h0;
    iREN         = 1'b0;
    iaddr        = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_lookup) begin
          ihit     = 1'b1;
          imemload = r_data[w_req_idx];
        end else if (imemREN) begin
          w_miss       = 1'b1;
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = r_miss_addr;
        if (!iwait) begin
          w_fill       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Miss address and valid bits; the address only loads on entry to FETCH
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_miss_addr <= 32'h0;
      r_valid     <= '0;
    end else begin
      if (w_miss) begin
        r_miss_addr <= imemaddr;
      end
      if (w_fill) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays; a fill overwrites the indexed entry unconditionally
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

endmodule
